subckt_stim_monitor: RTL and testbench

Self-test harness that sits on the other end of a 4-input, 1-output power sub-circuit. It generates pseudo-random input vectors, drives them into the sub-circuit, and captures the single-bit response. It reports switching activity (input and output toggle counts), the response one-count and a 16-bit response signature, so rewritten sub-circuits can be compared for equivalence and activity on silicon or in simulation.

---
 rtl/subckt_stim_monitor.sv | 166 ++++++++++++++++
 tb/tb_subckt_stim_monitor.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subckt_stim_monitor.sv
// Self-test harness for a 4-in/1-out sub-circuit: drives LFSR vectors, captures the
// response, and reports input/output toggle counts, response one-count and a CRC signature.
module subckt_stim_monitor #(
    parameter int unsigned N_VEC = 256,
    parameter int unsigned CNT_W = 16,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [3:0]       stim,
    input  logic             resp,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] in_toggles,
    output logic [CNT_W-1:0] out_toggles,
    output logic [CNT_W-1:0] ones_count,
    output logic [15:0]      signature
);

    localparam int unsigned VEC_W = 16;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(N_VEC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [15:0]      SIG_POLY = 16'h1021;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_load;
    logic   w_step;
    logic   w_last;

    logic [15:0]      r_lfsr;
    logic [VEC_W-1:0] r_vec_cnt;
    logic [3:0]       r_stim;
    logic [3:0]       r_prev_stim;
    logic             r_prev_resp;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_in_toggles;
    logic [CNT_W-1:0] r_out_toggles;
    logic [CNT_W-1:0] r_ones_count;
    logic [15:0]      r_signature;

    logic             w_fb;
    logic [15:0]      w_lfsr_next;
    logic [3:0]       w_tog;
    logic [SUM_W-1:0] w_in_sum;
    logic [CNT_W-1:0] w_in_next;
    logic             w_out_inc;
    logic [CNT_W-1:0] w_out_next;
    logic [CNT_W-1:0] w_ones_next;
    logic [15:0]      w_sig_next;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_vec_cnt == LAST_IDX) begin
                    w_last       = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Per-vector next values; counters saturate, signature wraps freely
    always_comb begin
        w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
        w_lfsr_next = {r_lfsr[14:0], w_fb};
        w_tog       = r_stim ^ r_prev_stim;
        w_in_sum    = SUM_W'(r_in_toggles) + SUM_W'(w_tog[0]) + SUM_W'(w_tog[1])
                    + SUM_W'(w_tog[2]) + SUM_W'(w_tog[3]);
        w_in_next   = (w_in_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_in_sum[CNT_W-1:0];
        w_out_inc   = resp ^ r_prev_resp;
        w_out_next  = (w_out_inc && (r_out_toggles != CNT_MAX))
                    ? r_out_toggles + CNT_W'(1) : r_out_toggles;
        w_ones_next = (resp && (r_ones_count != CNT_MAX))
                    ? r_ones_count + CNT_W'(1) : r_ones_count;
        w_sig_next  = {r_signature[14:0], 1'b0}
                    ^ (r_signature[15] ? SIG_POLY : 16'h0000)
                    ^ {15'b0, resp};
    end

    // Vector generation and result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr        <= SEED;
            r_vec_cnt     <= '0;
            r_stim        <= 4'h0;
            r_prev_stim   <= 4'h0;
            r_prev_resp   <= 1'b0;
            r_in_toggles  <= '0;
            r_out_toggles <= '0;
            r_ones_count  <= '0;
            r_signature   <= 16'h0000;
        end else if (w_load) begin
            r_lfsr        <= SEED;
            r_vec_cnt     <= '0;
            r_stim        <= SEED[3:0];
            r_prev_stim   <= 4'h0;
            r_prev_resp   <= 1'b0;
            r_in_toggles  <= '0;
            r_out_toggles <= '0;
            r_ones_count  <= '0;
            r_signature   <= 16'h0000;
        end else if (w_step) begin
            r_lfsr        <= w_lfsr_next;
            r_vec_cnt     <= r_vec_cnt + VEC_W'(1);
            r_stim        <= w_last ? 4'h0 : w_lfsr_next[3:0];
            r_prev_stim   <= r_stim;
            r_prev_resp   <= resp;
            r_in_toggles  <= w_in_next;
            r_out_toggles <= w_out_next;
            r_ones_count  <= w_ones_next;
            r_signature   <= w_sig_next;
        end
    end

    // Status flags track the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next_state == S_RUN);
            r_done <= (w_next_state == S_DONE);
        end
    end

    assign stim        = r_stim;
    assign busy        = r_busy;
    assign done        = r_done;
    assign in_toggles  = r_in_toggles;
    assign out_toggles = r_out_toggles;
    assign ones_count  = r_ones_count;
    assign signature   = r_signature;

endmodule

// File: tb/tb_subckt_stim_monitor.sv
// Bench for subckt_stim_monitor: three parameterisations checked against a
// vector-by-vector behavioural model of the run results.
module tb_subckt_stim_monitor;

    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // dut_a: default 256 vectors, resp selected by mode_a
    logic        start_a = 1'b0;
    logic [3:0]  stim_a;
    logic        resp_a;
    logic        busy_a, done_a;
    logic [15:0] it_a, ot_a, oc_a, sig_a;
    int          mode_a = 0;
    logic [15:0] tt_a = 16'h0000;

    // dut_b: 2 vectors, resp = stim[0]
    logic        start_b = 1'b0;
    logic [3:0]  stim_b;
    logic        busy_b, done_b;
    logic [15:0] it_b, ot_b, oc_b, sig_b;

    // dut_c: 64 vectors, 4-bit counters, resp = stim[1]
    logic        start_c = 1'b0;
    logic [3:0]  stim_c;
    logic        busy_c, done_c;
    logic [3:0]  it_c, ot_c, oc_c;
    logic [15:0] sig_c;

    function automatic logic golden(input logic [3:0] s);
        return (s[0] & s[1]) | (s[2] ^ s[3]);
    endfunction

    function automatic logic rewritten(input logic [3:0] s);
        return ~((~s[0] | ~s[1]) & ~((s[2] & ~s[3]) | (~s[2] & s[3])));
    endfunction

    function automatic logic ref_resp(input int mode, input logic [15:0] tt, input logic [3:0] s);
        case (mode)
            0:       return tt[s];
            1, 2:    return golden(s);
            3:       return 1'b1;
            4:       return s[0];
            default: return s[1];
        endcase
    endfunction

    always_comb begin
        case (mode_a)
            0:       resp_a = tt_a[stim_a];
            1:       resp_a = golden(stim_a);
            2:       resp_a = rewritten(stim_a);
            default: resp_a = 1'b1;
        endcase
    end

    subckt_stim_monitor dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stim(stim_a), .resp(resp_a),
        .busy(busy_a), .done(done_a), .in_toggles(it_a), .out_toggles(ot_a),
        .ones_count(oc_a), .signature(sig_a)
    );

    subckt_stim_monitor #(.N_VEC(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stim(stim_b), .resp(stim_b[0]),
        .busy(busy_b), .done(done_b), .in_toggles(it_b), .out_toggles(ot_b),
        .ones_count(oc_b), .signature(sig_b)
    );

    subckt_stim_monitor #(.N_VEC(64), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .stim(stim_c), .resp(stim_c[1]),
        .busy(busy_c), .done(done_c), .in_toggles(it_c), .out_toggles(ot_c),
        .ones_count(oc_c), .signature(sig_c)
    );

    // Expected results of one full run, straight from the vector-level rules
    task automatic model_run(input int nvec, input int cw, input int mode, input logic [15:0] tt,
                             output int e_it, output int e_ot, output int e_oc,
                             output logic [15:0] e_sig);
        int          mx;
        logic [15:0] l;
        logic [3:0]  s, ps;
        logic        r, pr;
        mx = (1 << cw) - 1;
        l = SEED; ps = 4'h0; pr = 1'b0;
        e_it = 0; e_ot = 0; e_oc = 0; e_sig = 16'h0000;
        for (int i = 0; i < nvec; i++) begin
            s = l[3:0];
            r = ref_resp(mode, tt, s);
            e_it = e_it + $countones(s ^ ps);
            if (e_it > mx) e_it = mx;
            if (r != pr) e_ot = e_ot + 1;
            if (e_ot > mx) e_ot = mx;
            if (r) e_oc = e_oc + 1;
            if (e_oc > mx) e_oc = mx;
            e_sig = {e_sig[14:0], 1'b0} ^ (e_sig[15] ? 16'h1021 : 16'h0000) ^ {15'b0, r};
            ps = s; pr = r;
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
    endtask

    // Launch a dut_a run; optionally pulse start again at RUN cycle inject_at
    task automatic run_a(input int inject_at, output int cycles);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || stim_a !== SEED[3:0]) begin
            failures++;
            $display("FAIL run_a_first_vec: busy=%b stim=%h expected busy=1 stim=%h",
                     busy_a, stim_a, SEED[3:0]);
        end
        cycles = 0;
        while (busy_a === 1'b1 && cycles < 2000) begin
            start_a = (cycles == inject_at);
            @(posedge clk); #1;
            cycles++;
        end
        start_a = 1'b0;
    endtask

    task automatic check_a(input string name, input int cycles);
        int e_it, e_ot, e_oc;
        logic [15:0] e_sig;
        model_run(256, 16, mode_a, tt_a, e_it, e_ot, e_oc, e_sig);
        checks++;
        if (cycles != 256) begin
            failures++; $display("FAIL %s_busy_cycles: got %0d expected 256", name, cycles);
        end
        checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || stim_a !== 4'h0) begin
            failures++;
            $display("FAIL %s_flags: done=%b busy=%b stim=%h expected 1 0 0", name, done_a, busy_a, stim_a);
        end
        checks++;
        if (it_a !== 16'(e_it)) begin
            failures++; $display("FAIL %s_in_toggles: got %0d expected %0d", name, it_a, e_it);
        end
        checks++;
        if (ot_a !== 16'(e_ot)) begin
            failures++; $display("FAIL %s_out_toggles: got %0d expected %0d", name, ot_a, e_ot);
        end
        checks++;
        if (oc_a !== 16'(e_oc)) begin
            failures++; $display("FAIL %s_ones_count: got %0d expected %0d", name, oc_a, e_oc);
        end
        checks++;
        if (sig_a !== e_sig) begin
            failures++; $display("FAIL %s_signature: got %h expected %h", name, sig_a, e_sig);
        end
    endtask

    task automatic check_a_cleared(input string name);
        checks++;
        if (stim_a !== 4'h0 || busy_a !== 1'b0 || done_a !== 1'b0 || it_a !== 16'h0 ||
            ot_a !== 16'h0 || oc_a !== 16'h0 || sig_a !== 16'h0) begin
            failures++;
            $display("FAIL %s: stim=%h busy=%b done=%b it=%h ot=%h oc=%h sig=%h expected all 0",
                     name, stim_a, busy_a, done_a, it_a, ot_a, oc_a, sig_a);
        end
    endtask

    task automatic test_reset();
        int c;
        check_a_cleared("reset_initial");
        mode_a = 0; tt_a = 16'($urandom) | 16'h0001;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (30) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_a_cleared("reset_async_midclock");
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_a_cleared("reset_stays_idle");
        c = 0;
    endtask

    task automatic test_two_vectors();
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        checks++;
        if (stim_b !== 4'h1 || busy_b !== 1'b1) begin
            failures++; $display("FAIL two_vec_first: stim=%h busy=%b expected 1 1", stim_b, busy_b);
        end
        @(posedge clk); #1;
        checks++;
        if (stim_b !== 4'h3 || busy_b !== 1'b1) begin
            failures++; $display("FAIL two_vec_second: stim=%h busy=%b expected 3 1", stim_b, busy_b);
        end
        @(posedge clk); #1;
        checks++;
        if (done_b !== 1'b1 || busy_b !== 1'b0 || stim_b !== 4'h0) begin
            failures++;
            $display("FAIL two_vec_done: done=%b busy=%b stim=%h expected 1 0 0", done_b, busy_b, stim_b);
        end
        checks++;
        if (it_b !== 16'd2 || ot_b !== 16'd1 || oc_b !== 16'd2 || sig_b !== 16'h0003) begin
            failures++;
            $display("FAIL two_vec_results: it=%0d ot=%0d oc=%0d sig=%h expected 2 1 2 0003",
                     it_b, ot_b, oc_b, sig_b);
        end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (done_b !== 1'b1 || it_b !== 16'd2 || sig_b !== 16'h0003) begin
            failures++;
            $display("FAIL two_vec_hold: done=%b it=%0d sig=%h expected 1 2 0003", done_b, it_b, sig_b);
        end
    endtask

    task automatic test_tied_zero();
        int c;
        mode_a = 0; tt_a = 16'h0000;
        run_a(-1, c);
        check_a("tied0", c);
        checks++;
        if (oc_a !== 16'h0 || ot_a !== 16'h0 || sig_a !== 16'h0) begin
            failures++;
            $display("FAIL tied0_zero_results: oc=%0d ot=%0d sig=%h expected 0 0 0000", oc_a, ot_a, sig_a);
        end
    endtask

    task automatic test_random_functions();
        int c;
        for (int k = 0; k < 3; k++) begin
            mode_a = 0; tt_a = 16'($urandom);
            run_a(-1, c);
            check_a($sformatf("rand%0d_tt%h", k, tt_a), c);
        end
    endtask

    task automatic test_compare();
        int c;
        logic [15:0] sig_gold, ot_gold, oc_gold;
        mode_a = 1; run_a(-1, c); check_a("golden", c);
        sig_gold = sig_a; ot_gold = ot_a; oc_gold = oc_a;
        mode_a = 2; run_a(-1, c); check_a("rewritten", c);
        checks++;
        if (sig_a !== sig_gold || ot_a !== ot_gold || oc_a !== oc_gold) begin
            failures++;
            $display("FAIL equiv_compare: sig=%h ot=%0d oc=%0d expected %h %0d %0d",
                     sig_a, ot_a, oc_a, sig_gold, ot_gold, oc_gold);
        end
        mode_a = 3; run_a(-1, c); check_a("stuck1", c);
        checks++;
        if (sig_a === sig_gold) begin
            failures++;
            $display("FAIL stuck1_detect: sig=%h expected anything but %h", sig_a, sig_gold);
        end
    endtask

    task automatic test_start_during_run();
        int c;
        mode_a = 0; tt_a = 16'($urandom);
        run_a(50, c);
        check_a("start_in_run", c);
    endtask

    task automatic test_reset_midrun();
        int c;
        mode_a = 0; tt_a = 16'($urandom) | 16'h8000;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (100) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_a_cleared("reset_at_vec100");
        #1 rst_n = 1'b1;
        run_a(-1, c);
        check_a("after_reset_rerun", c);
    endtask

    task automatic test_back_to_back();
        int c;
        mode_a = 0; tt_a = 16'($urandom);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1;
        c = 0;
        while (busy_a === 1'b1 && c < 2000) begin
            @(posedge clk); #1;
            c++;
        end
        check_a("b2b_first", c);
        @(posedge clk); #1 start_a = 1'b0;
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b1 || stim_a !== SEED[3:0]) begin
            failures++;
            $display("FAIL b2b_restart: done=%b busy=%b stim=%h expected 0 1 %h",
                     done_a, busy_a, stim_a, SEED[3:0]);
        end
        c = 0;
        while (busy_a === 1'b1 && c < 2000) begin
            @(posedge clk); #1;
            c++;
        end
        check_a("b2b_second", c);
    endtask

    task automatic test_saturate();
        int c;
        int e_it, e_ot, e_oc;
        logic [15:0] e_sig;
        model_run(64, 4, 5, 16'h0, e_it, e_ot, e_oc, e_sig);
        @(posedge clk); #1 start_c = 1'b1;
        @(posedge clk); #1 start_c = 1'b0;
        c = 0;
        while (busy_c === 1'b1 && c < 2000) begin
            @(posedge clk); #1;
            c++;
        end
        checks++;
        if (c != 64 || done_c !== 1'b1) begin
            failures++; $display("FAIL sat_run_len: cycles=%0d done=%b expected 64 1", c, done_c);
        end
        checks++;
        if (it_c !== 4'd15 || ot_c !== 4'd15 || oc_c !== 4'd15) begin
            failures++;
            $display("FAIL sat_counters: it=%0d ot=%0d oc=%0d expected 15 15 15", it_c, ot_c, oc_c);
        end
        checks++;
        if (sig_c !== e_sig) begin
            failures++; $display("FAIL sat_signature: got %h expected %h", sig_c, e_sig);
        end
    endtask

    initial begin
        #12 rst_n = 1'b1;
        #1;
        test_reset();
        test_two_vectors();
        test_tied_zero();
        test_random_functions();
        test_compare();
        test_start_during_run();
        test_reset_midrun();
        test_back_to_back();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
